sram_capture_ctrl: RTL and testbench
====================================

Name: sram_capture_ctrl

Overview:
- Downstream stage of the min/max/RLE sampling path.
- Takes the per-clock channel A/B bytes and the address-count enable, and writes them as 16-bit words into the external SRAM ring buffer.
- Owns the capture sequence: pre-trigger fill, armed wait, post-trigger count, done.
- Latches the trigger address so the MCU can unroll the ring.

Parameters:
ADDR_W, 19, SRAM word address width; the ring buffer is 2^ADDR_W words.

Ports:
CLK  in  1  sampling clock, rising edge.
nRST  in  1  asynchronous active-low reset.
START  in  1  one-cycle pulse; begins a capture.
ABORT  in  1  one-cycle pulse; cancels the capture and returns to IDLE.
TRIG  in  1  trigger pulse from the sync comparator.
ADDR_CNT_EN  in  1  sample-valid; high = write this cycle's data.
DATA_A  in  8  channel A / LA data byte.
DATA_B  in  8  channel B / RLE code byte.
PRE_CNT  in  ADDR_W  samples written before a trigger is accepted.
POST_CNT  in  ADDR_W  samples written after the trigger.
SRAM_ADDR  out  ADDR_W  SRAM word address.
SRAM_DQ  out  16  write data, {DATA_B, DATA_A}.
SRAM_nWE  out  1  active-low write strobe, one cycle per word.
BUSY  out  1  high in PRE, ARMED and POST.
DONE  out  1  high in DONE.
TRIG_ADDR  out  ADDR_W  address of the trigger sample.

Behaviour:
- Reset (nRST low, asynchronous): state IDLE, SRAM_ADDR=0, SRAM_DQ=0, SRAM_nWE=1, BUSY=0, DONE=0, TRIG_ADDR=0, all internal counters 0.
- States: IDLE, PRE, ARMED, POST, DONE. All outputs are registered.
- IDLE, START=1:
  - Write address is cleared to 0 and the pre-counter to 0.
  - Next state is PRE, or ARMED if PRE_CNT=0.
- Write rule:
  - In PRE, ARMED or POST, ADDR_CNT_EN=1 in cycle n gives, in cycle n+1: SRAM_nWE=0, SRAM_DQ={DATA_B,DATA_A} from cycle n, SRAM_ADDR = current write address.
  - The write address then increments, wrapping from 2^ADDR_W-1 to 0.
  - With ADDR_CNT_EN=0: SRAM_nWE=1, and SRAM_ADDR and SRAM_DQ hold.
  - Latency is exactly 1 cycle. No writes occur in IDLE or DONE.
- PRE:
  - Each write increments the pre-counter.
  - When a write brings it to PRE_CNT, the next state is ARMED.
  - TRIG is ignored in PRE, including on the transition cycle.
- ARMED:
  - Writes continue circularly.
  - TRIG=1 in cycle n latches TRIG_ADDR = the address written for cycle n's sample if ADDR_CNT_EN=1, else the next address to be written.
  - On TRIG the post-counter clears and the next state is POST, or DONE if POST_CNT=0. The trigger-cycle sample is still written.
- POST:
  - Writes after the trigger cycle increment the post-counter.
  - When it reaches POST_CNT, the state goes to DONE after that write is issued.
  - TRIG is ignored.
- DONE:
  - DONE=1, BUSY=0, SRAM_nWE=1.
  - Addresses hold; the final write address is readable through SRAM_ADDR.
  - START restarts the capture as from IDLE. DONE clears on START or ABORT.
- START while BUSY is ignored.
- ABORT in any state:
  - Next state is IDLE and SRAM_nWE goes to 1 next cycle.
  - TRIG_ADDR holds; BUSY=0, DONE=0.
  - ABORT and START in the same cycle: ABORT wins.
- PRE_CNT or POST_CNT > 2^ADDR_W-1 cannot occur (width-limited). PRE_CNT is sampled continuously; the MCU keeps it stable while BUSY.
- PRE_CNT + POST_CNT > ring size: ring overwrite is permitted, with no error flag.
- nRST asserted mid-capture: immediate return to reset values; no partial write strobe beyond the reset edge.

Test Plan:
1. ADDR_W=4, PRE_CNT=3, POST_CNT=2, ADDR_CNT_EN=1 constantly, START, then TRIG 6 cycles later:
   - writes at addr 0,1,2 (PRE), then ARMED, TRIG_ADDR = address of the trigger-cycle write;
   - exactly 2 further writes, then DONE=1, BUSY=0, nWE=1.
2. TRIG pulsed during PRE (PRE_CNT=5) -> ignored; state reaches ARMED only after 5 writes; TRIG_ADDR unchanged (0).
3. ADDR_W=4, PRE_CNT=2, no TRIG for 20 samples -> address sequence wraps 15->0; nWE pulses on every sample; BUSY stays 1.
4. ADDR_CNT_EN toggled 1,0,1,0 in ARMED/POST, POST_CNT=2 -> nWE low only in cycles following EN=1; POST ends after 2 enabled samples, not 2 cycles.
5. PRE_CNT=0, POST_CNT=0, START then TRIG on the next cycle -> PRE skipped; one trigger-sample write; DONE the following cycle.
6. ABORT and START together in POST -> IDLE, BUSY=0, DONE=0; then nRST pulsed mid-PRE -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/sram_capture_ctrl.sv
// Capture sequencer for the sampling path: packs channel bytes into 16-bit words,
// writes them circularly into external SRAM and records where the trigger landed.
module sram_capture_ctrl #(
  parameter int ADDR_W = 19
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  input  logic              ABORT,
  input  logic              TRIG,
  input  logic              ADDR_CNT_EN,
  input  logic [7:0]        DATA_A,
  input  logic [7:0]        DATA_B,
  input  logic [ADDR_W-1:0] PRE_CNT,
  input  logic [ADDR_W-1:0] POST_CNT,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]       SRAM_DQ,
  output logic              SRAM_nWE,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] TRIG_ADDR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [ADDR_W-1:0] pre_cnt_reg, pre_cnt_next;
  logic [ADDR_W-1:0] post_cnt_reg, post_cnt_next;
  logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
  logic [15:0]       sram_dq_reg, sram_dq_next;
  logic              sram_nwe_reg, sram_nwe_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;

  logic              active;
  logic              wr;
  logic              start_ok;
  logic              trig_ok;
  logic [ADDR_W-1:0] pre_inc;
  logic [ADDR_W-1:0] post_inc;

  // ABORT masks every other event in the same cycle, including the write.
  assign active   = (state_reg == S_PRE) || (state_reg == S_ARMED) || (state_reg == S_POST);
  assign wr       = active && ADDR_CNT_EN && !ABORT;
  assign start_ok = ((state_reg == S_IDLE) || (state_reg == S_DONE)) && START && !ABORT;
  assign trig_ok  = (state_reg == S_ARMED) && TRIG && !ABORT;
  assign pre_inc  = pre_cnt_reg + ADDR_W'(1);
  assign post_inc = post_cnt_reg + ADDR_W'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (START) state_next = (PRE_CNT == '0) ? S_ARMED : S_PRE;
      end
      S_PRE: begin
        if (ADDR_CNT_EN && (pre_inc == PRE_CNT)) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (TRIG) state_next = (POST_CNT == '0) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (ADDR_CNT_EN && (post_inc == POST_CNT)) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
    if (ABORT) state_next = S_IDLE;
  end

  always_comb begin
    wr_addr_next   = wr_addr_reg;
    pre_cnt_next   = pre_cnt_reg;
    post_cnt_next  = post_cnt_reg;
    sram_addr_next = sram_addr_reg;
    sram_dq_next   = sram_dq_reg;
    sram_nwe_next  = !wr;
    trig_addr_next = trig_addr_reg;
    busy_next      = (state_next == S_PRE) || (state_next == S_ARMED) || (state_next == S_POST);
    done_next      = (state_next == S_DONE);

    if (wr) begin
      sram_addr_next = wr_addr_reg;
      sram_dq_next   = {DATA_B, DATA_A};
      wr_addr_next   = wr_addr_reg + ADDR_W'(1);
    end
    if (wr && (state_reg == S_PRE)) pre_cnt_next = pre_inc;
    if (wr && (state_reg == S_POST)) post_cnt_next = post_inc;

    // The trigger sample, if any, is written at wr_addr_reg; otherwise that is the next slot.
    if (trig_ok) begin
      trig_addr_next = wr_addr_reg;
      post_cnt_next  = '0;
    end

    if (start_ok) begin
      wr_addr_next = '0;
      pre_cnt_next = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_addr_reg   <= '0;
      pre_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      sram_addr_reg <= '0;
      sram_dq_reg   <= '0;
      sram_nwe_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      trig_addr_reg <= '0;
    end else begin
      wr_addr_reg   <= wr_addr_next;
      pre_cnt_reg   <= pre_cnt_next;
      post_cnt_reg  <= post_cnt_next;
      sram_addr_reg <= sram_addr_next;
      sram_dq_reg   <= sram_dq_next;
      sram_nwe_reg  <= sram_nwe_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      trig_addr_reg <= trig_addr_next;
    end
  end

  assign SRAM_ADDR = sram_addr_reg;
  assign SRAM_DQ   = sram_dq_reg;
  assign SRAM_nWE  = sram_nwe_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign TRIG_ADDR = trig_addr_reg;

endmodule

// File: tb/tb_sram_capture_ctrl.sv
// Directed bench for sram_capture_ctrl with a 16-word ring (ADDR_W=4).
module tb_sram_capture_ctrl;

  localparam int AW = 4;

  logic          CLK;
  logic          nRST;
  logic          START;
  logic          ABORT;
  logic          TRIG;
  logic          ADDR_CNT_EN;
  logic [7:0]    DATA_A;
  logic [7:0]    DATA_B;
  logic [AW-1:0] PRE_CNT;
  logic [AW-1:0] POST_CNT;
  logic [AW-1:0] SRAM_ADDR;
  logic [15:0]   SRAM_DQ;
  logic          SRAM_nWE;
  logic          BUSY;
  logic          DONE;
  logic [AW-1:0] TRIG_ADDR;

  int n_cmp = 0;
  int n_bad = 0;

  sram_capture_ctrl #(.ADDR_W(AW)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .ABORT(ABORT), .TRIG(TRIG),
    .ADDR_CNT_EN(ADDR_CNT_EN), .DATA_A(DATA_A), .DATA_B(DATA_B),
    .PRE_CNT(PRE_CNT), .POST_CNT(POST_CNT), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ(SRAM_DQ), .SRAM_nWE(SRAM_nWE), .BUSY(BUSY), .DONE(DONE),
    .TRIG_ADDR(TRIG_ADDR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs set here form one sample cycle; outputs are read 1 ns after the closing edge.
  task automatic drive(input logic st, input logic ab, input logic tr, input logic en,
                       input logic [7:0] a, input logic [7:0] b);
    START = st; ABORT = ab; TRIG = tr; ADDR_CNT_EN = en; DATA_A = a; DATA_B = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_wr(input string tag, input int addr, input logic [15:0] dq);
    check_val({tag, ".nwe"}, 32'(SRAM_nWE), 32'd0);
    check_val({tag, ".addr"}, 32'(SRAM_ADDR), 32'(addr));
    check_val({tag, ".dq"}, 32'(SRAM_DQ), 32'(dq));
  endtask

  task automatic exp_nowr(input string tag, input int addr);
    check_val({tag, ".nwe"}, 32'(SRAM_nWE), 32'd1);
    check_val({tag, ".addr"}, 32'(SRAM_ADDR), 32'(addr));
  endtask

  task automatic exp_st(input string tag, input logic busy, input logic done);
    check_val({tag, ".busy"}, 32'(BUSY), 32'(busy));
    check_val({tag, ".done"}, 32'(DONE), 32'(done));
  endtask

  task automatic exp_trig(input string tag, input int addr);
    check_val({tag, ".trig_addr"}, 32'(TRIG_ADDR), 32'(addr));
  endtask

  task automatic exp_reset(input string tag);
    exp_nowr(tag, 0);
    check_val({tag, ".dq"}, 32'(SRAM_DQ), 32'd0);
    exp_st(tag, 1'b0, 1'b0);
    exp_trig(tag, 0);
  endtask

  task automatic pulse_reset(input string tag);
    nRST = 1'b0;
    #1;
    exp_reset(tag);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    nRST = 1'b1; START = 0; ABORT = 0; TRIG = 0; ADDR_CNT_EN = 0;
    DATA_A = 0; DATA_B = 0; PRE_CNT = 0; POST_CNT = 0;
    #3 nRST = 1'b0;
    #1 exp_reset("rst0");
    @(negedge CLK);
    nRST = 1'b1;

    // 1: PRE_CNT=3, POST_CNT=2, EN always 1, TRIG six cycles after START
    PRE_CNT = 4'd3; POST_CNT = 4'd2;
    drive(1, 0, 0, 1, 8'h00, 8'h00);
    exp_nowr("t1.start", 0);
    exp_st("t1.start", 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      a = 8'(i);
      b = 8'(8'hA0 + i);
      drive(0, 0, (i == 6), 1, a, b);
      exp_wr($sformatf("t1.c%0d", i), i - 1, {b, a});
      exp_st($sformatf("t1.c%0d", i), (i < 8), (i == 8));
      if (i >= 6) exp_trig($sformatf("t1.c%0d", i), 5);
    end
    drive(0, 0, 0, 1, 8'h55, 8'h66);
    exp_nowr("t1.end", 7);
    exp_st("t1.end", 1'b0, 1'b1);
    exp_trig("t1.end", 5);

    // 2: TRIG held through PRE (PRE_CNT=5) is ignored until ARMED
    pulse_reset("t2.rst");
    PRE_CNT = 4'd5; POST_CNT = 4'd2;
    drive(1, 0, 0, 1, 8'h00, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      a = 8'(8'h10 + i);
      drive(0, 0, 1, 1, a, 8'h20);
      exp_wr($sformatf("t2.c%0d", i), i - 1, {8'h20, a});
      exp_trig($sformatf("t2.c%0d", i), 0);
    end
    drive(0, 0, 1, 1, 8'h16, 8'h20);
    exp_wr("t2.c6", 5, 16'h2016);
    exp_trig("t2.c6", 5);
    exp_st("t2.c6", 1'b1, 1'b0);
    drive(0, 0, 0, 1, 8'h17, 8'h20);
    exp_wr("t2.c7", 6, 16'h2017);
    exp_st("t2.c7", 1'b1, 1'b0);

    // 6a: ABORT with START in POST -> IDLE, START not honoured
    drive(1, 1, 0, 1, 8'h99, 8'h99);
    exp_nowr("t6.abort", 6);
    exp_st("t6.abort", 1'b0, 1'b0);
    exp_trig("t6.abort", 5);
    drive(0, 0, 0, 1, 8'h98, 8'h98);
    exp_nowr("t6.idle", 6);
    exp_st("t6.idle", 1'b0, 1'b0);

    // 3: 20 samples with no TRIG wrap the 16-word ring
    PRE_CNT = 4'd2; POST_CNT = 4'd2;
    drive(1, 0, 0, 1, 8'h00, 8'h00);
    exp_st("t3.start", 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      a = 8'(i);
      b = ~a;
      drive(0, 0, 0, 1, a, b);
      exp_wr($sformatf("t3.c%0d", i), (i - 1) % 16, {b, a});
      exp_st($sformatf("t3.c%0d", i), 1'b1, 1'b0);
    end
    drive(0, 0, 1, 0, 8'hEE, 8'hEE);
    exp_nowr("t3.trig", 3);
    exp_trig("t3.trig", 4);
    exp_st("t3.trig", 1'b1, 1'b0);
    drive(0, 1, 0, 1, 8'hEE, 8'hEE);
    exp_nowr("t3.abort", 3);
    exp_st("t3.abort", 1'b0, 1'b0);

    // 4: EN gaps in ARMED and POST; POST counts enabled samples only
    PRE_CNT = 4'd1; POST_CNT = 4'd2;
    drive(1, 0, 0, 1, 8'h00, 8'h00);
    drive(0, 0, 0, 1, 8'h41, 8'h00);
    exp_wr("t4.c1", 0, 16'h0041);
    drive(0, 0, 0, 0, 8'h42, 8'h00);
    exp_nowr("t4.c2", 0);
    drive(0, 0, 1, 1, 8'h43, 8'h00);
    exp_wr("t4.c3", 1, 16'h0043);
    exp_trig("t4.c3", 1);
    drive(0, 0, 0, 0, 8'h44, 8'h00);
    exp_nowr("t4.c4", 1);
    exp_st("t4.c4", 1'b1, 1'b0);
    drive(0, 0, 0, 1, 8'h45, 8'h00);
    exp_wr("t4.c5", 2, 16'h0045);
    drive(0, 0, 0, 0, 8'h46, 8'h00);
    exp_nowr("t4.c6", 2);
    exp_st("t4.c6", 1'b1, 1'b0);
    drive(0, 0, 0, 1, 8'h47, 8'h00);
    exp_wr("t4.c7", 3, 16'h0047);
    exp_st("t4.c7", 1'b0, 1'b1);
    drive(0, 0, 0, 1, 8'h48, 8'h00);
    exp_nowr("t4.c8", 3);
    exp_st("t4.c8", 1'b0, 1'b1);

    // 5: PRE_CNT=POST_CNT=0, restart from DONE, TRIG next cycle
    PRE_CNT = 4'd0; POST_CNT = 4'd0;
    drive(1, 0, 0, 1, 8'h11, 8'h11);
    exp_nowr("t5.start", 3);
    exp_st("t5.start", 1'b1, 1'b0);
    drive(0, 0, 1, 1, 8'h5A, 8'hC3);
    exp_wr("t5.trig", 0, 16'hC35A);
    exp_trig("t5.trig", 0);
    exp_st("t5.trig", 1'b0, 1'b1);
    drive(0, 0, 0, 1, 8'h12, 8'h12);
    exp_nowr("t5.done", 0);
    exp_st("t5.done", 1'b0, 1'b1);

    // 6b: asynchronous reset mid-PRE while a write strobe is active
    PRE_CNT = 4'd5; POST_CNT = 4'd2;
    drive(1, 0, 0, 1, 8'h00, 8'h00);
    drive(0, 0, 0, 1, 8'h61, 8'h62);
    drive(0, 0, 0, 1, 8'h63, 8'h64);
    exp_wr("t6.pre", 1, 16'h6463);
    nRST = 1'b0;
    #1 exp_reset("t6.rst");
    @(posedge CLK);
    #1 exp_nowr("t6.hold", 0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(0, 0, 0, 1, 8'h65, 8'h66);
    exp_nowr("t6.after", 0);
    exp_st("t6.after", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
